data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-index width; the array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 2: number of BUSY cycles per access; legal range is 1..15.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 mem_ren  input  1: read request from the CPU MEM stage; held by the CPU while stalled.
REQ-007 mem_wen  input  1: write request from the CPU MEM stage; held by the CPU while stalled.
REQ-008 mem_addr  input  32: byte address of the access.
REQ-009 mem_dout  input  32: write data from the CPU.
REQ-010 mem_din  output  32: read data returned to the CPU.
REQ-011 mem_stall  output  1: freezes the CPU pipeline while an access is in flight.
REQ-012 addr_err  output  1: one-cycle pulse reporting a misaligned access or a conflicting request.

Function
REQ-013 The FSM SHALL have three states, IDLE, BUSY and DONE, with a 4-bit down-counter cnt.
REQ-014 In IDLE with (mem_ren|mem_wen)=1, the block SHALL latch the operation, mem_addr and mem_dout, load cnt=LATENCY-1, and go to BUSY.
REQ-015 In BUSY, if cnt!=0 the block SHALL decrement cnt; if cnt==0 it SHALL commit the access and go to DONE.
REQ-016 DONE SHALL return to IDLE unconditionally after one cycle and SHALL ignore request inputs during that cycle.
REQ-017 mem_stall SHALL be combinational: 1 when (IDLE and a request is present) or in BUSY; 0 in DONE and in an idle IDLE.
REQ-018 Stall length SHALL be LATENCY+1 cycles; one access occupies LATENCY+2 cycles, IDLE-accept through DONE.
REQ-019 The word index SHALL be addr[ADDR_WIDTH+1:2]; higher address bits are ignored, so addresses wrap modulo the array size.
REQ-020 A write SHALL update the array on the BUSY->DONE edge.
REQ-021 A read SHALL register array[index] into mem_din on the BUSY->DONE edge.
REQ-022 mem_din SHALL hold its value until the next read commits; writes SHALL NOT change mem_din.
REQ-023 If addr[1:0]!=0 at accept, the block SHALL suppress any write, load mem_din=0 for a read, and pulse addr_err in DONE.
REQ-024 If mem_ren and mem_wen are both 1 at accept, the block SHALL perform the write only (mem_din unchanged) and pulse addr_err in DONE.
REQ-025 The latched request SHALL complete even if mem_ren/mem_wen fall during BUSY; inputs are sampled only in IDLE.
REQ-026 Back-to-back requests: a request present in the cycle after DONE SHALL be accepted in IDLE with no extra gap.

Reset
REQ-027 While rst_n=0 the block SHALL force state=IDLE, cnt=0, mem_din=0, addr_err=0, and clear latched operation, address and data.
REQ-028 Assertion of rst_n during BUSY SHALL abort the access; a pending write SHALL NOT reach the array.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 mem_stall SHALL be 0 during reset regardless of request inputs.

Verification
REQ-031 LATENCY=2, write 0xDEADBEEF to 0x10, then read 0x10 -> mem_stall high for 3 cycles per access; mem_din=0xDEADBEEF in the read's DONE cycle.
REQ-032 Read 0x13 (misaligned) -> mem_din=0, addr_err pulses exactly once in DONE, and the array is unchanged.
REQ-033 With ADDR_WIDTH=10, write 0x1234 to 0x1004, then read 0x4 -> mem_din=0x1234 (wrap).
REQ-034 mem_ren=mem_wen=1, addr 0x20, data 0x55 -> subsequent read of 0x20 returns 0x55; addr_err pulses once; mem_din unchanged until that read.
REQ-035 rst_n low in the second BUSY cycle of a write of 0xAA to 0x40 -> mem_stall=0 and state IDLE immediately; a later read of 0x40 returns the prior contents.
REQ-036 Drop mem_wen one cycle after accept -> the write still commits, and DONE occurs at the same cycle as an undisturbed write.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers CPU MEM-stage requests after a fixed
// number of busy cycles, stalling the pipeline while an access is in flight.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_op_wr;
    logic                    r_op_rd;
    logic                    r_misalign;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_mem_din;
    logic                    r_addr_err;
    logic [31:0]             r_mem [2**ADDR_WIDTH];

    logic                    w_req;
    logic                    w_commit;
    logic                    w_do_write;
    logic                    w_unused_addr;

    assign w_req         = mem_ren | mem_wen;
    assign w_commit      = (r_state == BUSY) && (r_cnt == 4'd0);
    // Misaligned writes are dropped; a read+write conflict resolves to the write.
    assign w_do_write    = rst_n & w_commit & r_op_wr & ~r_misalign;
    assign w_unused_addr = ^mem_addr[31:ADDR_WIDTH+2];

    assign mem_stall = rst_n & (((r_state == IDLE) & w_req) | (r_state == BUSY));
    assign mem_din   = r_mem_din;
    assign addr_err  = r_addr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_wr    <= 1'b0;
            r_op_rd    <= 1'b0;
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_mem_din  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_op_wr    <= mem_wen;
                        r_op_rd    <= mem_ren & ~mem_wen;
                        r_misalign <= (mem_addr[1:0] != 2'b00);
                        r_err      <= (mem_addr[1:0] != 2'b00) | (mem_ren & mem_wen);
                        r_idx      <= mem_addr[ADDR_WIDTH+1:2];
                        r_wdata    <= mem_dout;
                        r_cnt      <= 4'(LATENCY - 1);
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_op_rd) begin
                            r_mem_din <= r_misalign ? '0 : r_mem[r_idx];
                        end
                        r_addr_err <= r_err;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Array storage carries no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
